// File: rtl/tlp_xcvr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlp_xcvr_pkg
// Desc     : Shared types and constants for the PCIe TLP transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package tlp_xcvr_pkg;

    localparam int MAX_TX_REQ = 4;

    typedef logic [1:0] ArbIdx;

    typedef enum logic [0:0] {
        S_ARB = 1'b0,
        S_OWN = 1'b1
    } TxArbState;

    function automatic ArbIdx rrIdx(input ArbIdx base, input int offset, input int n);
        return ArbIdx'((int'(base) + offset) % n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlp_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : tlp_rr_pick
// Desc     : Combinational round-robin winner search from a pend mask.
// Revision : 1.0 - initial release
// ============================================================================
module tlp_rr_pick
    import tlp_xcvr_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_pend,
    input  ArbIdx              i_lastGrant,
    output ArbIdx              o_winner,
    output logic               o_anyPend
);

    logic [MAX_TX_REQ-1:0] w_pendExt;

    assign w_pendExt = MAX_TX_REQ'(i_pend);
    assign o_anyPend = |i_pend;

    // Walk from the farthest offset to the nearest so the nearest pending source wins.
    always_comb begin
        o_winner = i_lastGrant;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (w_pendExt[rrIdx(i_lastGrant, i, NUM_REQ)]) begin
                o_winner = rrIdx(i_lastGrant, i, NUM_REQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlp_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tlp_tx_arb
// Desc     : Packet-granular round-robin arbiter for the shared PCIe TX channel.
//            Optional idle watchdog compiled in with TLP_TX_ARB_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tlp_tx_arb
    import tlp_xcvr_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int WDOG_LIMIT = 255
) (
    input  logic                     pcieClk_in,
    input  logic                     pcieRstN_in,
    input  logic [NUM_REQ-1:0]       reqPend_in,
    input  logic [NUM_REQ-1:0][63:0] reqData_in,
    input  logic [NUM_REQ-1:0]       reqValid_in,
    input  logic [NUM_REQ-1:0]       reqSOP_in,
    input  logic [NUM_REQ-1:0]       reqEOP_in,
    output logic [NUM_REQ-1:0]       reqReady_out,
    output logic [63:0]              txData_out,
    output logic                     txValid_out,
    output logic                     txSOP_out,
    output logic                     txEOP_out,
    input  logic                     txReady_in,
    output logic [1:0]               grantId_out,
    output logic                     grantValid_out,
`ifdef TLP_TX_ARB_WDOG_EN
    output logic                     wdogTrip_out,
`endif
    output logic                     protoErr_out
);

    localparam logic [0:0] c_S_ARB = S_ARB;
    localparam logic [0:0] c_S_OWN = S_OWN;

    logic [0:0] r_state;
    ArbIdx      r_owner;
    ArbIdx      r_lastGrant;
    logic       r_firstBeat;
    logic       r_protoErr;

    ArbIdx      w_winner;
    logic       w_anyPend;
    logic       w_own;
    logic       w_xfer;
    logic       w_nonOwnerValid;

    logic [MAX_TX_REQ-1:0][63:0] w_dataExt;
    logic [MAX_TX_REQ-1:0]       w_validExt;
    logic [MAX_TX_REQ-1:0]       w_sopExt;
    logic [MAX_TX_REQ-1:0]       w_eopExt;
    logic [MAX_TX_REQ-1:0]       w_ownMask;

    // Pad the source bundle to the maximum width so owner indexing is always in range.
    for (genvar gi = 0; gi < MAX_TX_REQ; gi++) begin : g_ext
        if (gi < NUM_REQ) begin : g_src
            assign w_dataExt[gi]  = reqData_in[gi];
            assign w_validExt[gi] = reqValid_in[gi];
            assign w_sopExt[gi]   = reqSOP_in[gi];
            assign w_eopExt[gi]   = reqEOP_in[gi];
        end else begin : g_pad
            assign w_dataExt[gi]  = '0;
            assign w_validExt[gi] = 1'b0;
            assign w_sopExt[gi]   = 1'b0;
            assign w_eopExt[gi]   = 1'b0;
        end
    end

    tlp_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rrPick (
        .i_pend      (reqPend_in),
        .i_lastGrant (r_lastGrant),
        .o_winner    (w_winner),
        .o_anyPend   (w_anyPend)
    );

    assign w_own           = (r_state == c_S_OWN);
    assign w_ownMask       = w_own ? (MAX_TX_REQ'(1) << r_owner) : '0;
    assign w_nonOwnerValid = |(w_validExt & ~w_ownMask);

    assign reqReady_out   = w_ownMask[NUM_REQ-1:0] & {NUM_REQ{txReady_in}};
    assign txData_out     = w_dataExt[r_owner];
    assign txValid_out    = w_own & w_validExt[r_owner];
    assign txSOP_out      = w_own & w_sopExt[r_owner];
    assign txEOP_out      = w_own & w_eopExt[r_owner];
    assign grantId_out    = w_own ? r_owner : 2'd0;
    assign grantValid_out = w_own;
    assign protoErr_out   = r_protoErr;
    assign w_xfer         = txValid_out & txReady_in;

`ifdef TLP_TX_ARB_WDOG_EN
    localparam logic [7:0] c_WDOG_TRIP = 8'(WDOG_LIMIT - 1);
    logic [7:0] r_wdog;
    logic       r_wdogTrip;
    assign wdogTrip_out = r_wdogTrip;
`endif

    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstN_in) begin
            r_state     <= c_S_ARB;
            r_owner     <= '0;
            r_lastGrant <= ArbIdx'(NUM_REQ - 1);
            r_firstBeat <= 1'b1;
            r_protoErr  <= 1'b0;
`ifdef TLP_TX_ARB_WDOG_EN
            r_wdog      <= '0;
            r_wdogTrip  <= 1'b0;
`endif
        end else begin
            // Owner beats must carry SOP exactly on the first beat of the packet.
            if (w_nonOwnerValid || (w_xfer && (r_firstBeat != txSOP_out))) begin
                r_protoErr <= 1'b1;
            end
            case (r_state)
                c_S_ARB: begin
                    if (w_anyPend) begin
                        r_state     <= c_S_OWN;
                        r_owner     <= w_winner;
                        r_lastGrant <= w_winner;
                        r_firstBeat <= 1'b1;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        r_firstBeat <= 1'b0;
                        if (txEOP_out) begin
                            r_state <= c_S_ARB;
                        end
                    end
                end
            endcase
`ifdef TLP_TX_ARB_WDOG_EN
            if (w_own && !w_xfer) begin
                if (r_wdog == c_WDOG_TRIP) begin
                    r_state    <= c_S_ARB;
                    r_wdogTrip <= 1'b1;
                    r_protoErr <= 1'b1;
                    r_wdog     <= '0;
                end else begin
                    r_wdog <= r_wdog + 8'd1;
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

endmodule
`default_nettype wire
